// File: rtl/ps2_key_tracker_pkg.sv
// Shared definitions for the PS/2 keyboard path: scancode constants, decoder
// state encoding and the key_state bit layout used by the ASCII converter.
package ps2_key_tracker_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    typedef enum logic [1:0] {
        DEC_IDLE    = 2'd0,
        DEC_EXT     = 2'd1,
        DEC_BRK     = 2'd2,
        DEC_EXT_BRK = 2'd3
    } dec_state_t;

    // key_state = {caps_lock, shift}; the ASCII table select uses the same bits.
    localparam int KS_SHIFT = 0;
    localparam int KS_CAPS  = 1;

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == SC_EXT) || (b == SC_BRK);
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises the raw lines, samples data on ps2_clk
// falling edges and emits one byte per good 11-bit frame or an error pulse.
module ps2_frame_rx #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [2:0]    r_clk_sync;
    logic [2:0]    r_dat_sync;
    logic          r_clk_prev;
    logic [3:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_parity;
    logic [TW-1:0] r_idle_cnt;
    logic [7:0]    r_byte;
    logic          r_byte_valid;
    logic          r_err;

    logic w_fall;
    logic w_bit;

    assign w_fall = r_clk_prev & ~r_clk_sync[2];
    assign w_bit  = r_dat_sync[2];

    assign o_byte       = r_byte;
    assign o_byte_valid = r_byte_valid;
    assign o_err        = r_err;

    // r_bit_cnt: 0 waits for start, 1..8 data, 9 parity, 10 stop.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_clk_sync   <= 3'b111;
            r_dat_sync   <= 3'b111;
            r_clk_prev   <= 1'b1;
            r_bit_cnt    <= 4'd0;
            r_shift      <= 8'h00;
            r_parity     <= 1'b0;
            r_idle_cnt   <= '0;
            r_byte       <= 8'h00;
            r_byte_valid <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_clk_sync   <= {r_clk_sync[1:0], i_ps2_clk};
            r_dat_sync   <= {r_dat_sync[1:0], i_ps2_data};
            r_clk_prev   <= r_clk_sync[2];
            r_byte_valid <= 1'b0;
            r_err        <= 1'b0;
            if (w_fall) begin
                r_idle_cnt <= '0;
                case (r_bit_cnt)
                    4'd0: begin
                        if (!w_bit) r_bit_cnt <= 4'd1;
                        else        r_err     <= 1'b1;
                    end
                    4'd9: begin
                        r_parity  <= w_bit;
                        r_bit_cnt <= 4'd10;
                    end
                    4'd10: begin
                        r_bit_cnt <= 4'd0;
                        if (w_bit && (^{r_shift, r_parity})) begin
                            r_byte       <= r_shift;
                            r_byte_valid <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    default: begin
                        r_shift   <= {w_bit, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end
                endcase
            end else if (r_bit_cnt != 4'd0) begin
                // A stalled partial frame is dropped silently so the next start bit resyncs.
                if (r_idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    r_bit_cnt  <= 4'd0;
                    r_idle_cnt <= '0;
                end else begin
                    r_idle_cnt <= r_idle_cnt + TW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 key tracker: frame receiver, byte FIFO and E0/F0 prefix decoder with
// Shift/CapsLock tracking, presenting key-make events over valid/ready.
module ps2_key_tracker
    import ps2_key_tracker_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       key_ready,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic [1:0] key_state,
    output logic       caps_led,
    output logic       frame_err,
    output logic       overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

    logic [7:0] w_rx_byte;
    logic       w_rx_valid;
    logic       w_rx_err;

    ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_frame_rx (
        .clk          (clk),
        .clrn         (clrn),
        .i_ps2_clk    (ps2_clk),
        .i_ps2_data   (ps2_data),
        .o_byte       (w_rx_byte),
        .o_byte_valid (w_rx_valid),
        .o_err        (w_rx_err)
    );

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;
    logic          r_frame_err;

    dec_state_t r_state;
    logic       r_lshift;
    logic       r_rshift;
    logic       r_caps;
    logic       r_caps_held;
    logic       r_key_valid;
    logic [7:0] r_key_code;
    logic       r_key_ext;
    logic [1:0] r_key_state;

    logic       w_full;
    logic       w_empty;
    logic       w_pop;
    logic       w_push;
    logic [7:0] w_byte;
    logic       w_is_prefix;
    logic       w_ext_ctx;
    logic       w_make;
    logic       w_brk;
    logic       w_is_lshift;
    logic       w_is_rshift;
    logic       w_is_caps;
    logic       w_is_fake;
    logic       w_event;

    assign w_full  = (r_count == FULL_COUNT);
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && (!r_key_valid || key_ready);
    // A push into a full FIFO still succeeds when the same cycle frees a slot.
    assign w_push  = w_rx_valid && (!w_full || w_pop);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
            else if (!w_push && w_pop) r_count <= r_count - (AW+1)'(1);
            if (w_rx_valid && !w_push) r_overflow  <= 1'b1;
            if (w_rx_err)              r_frame_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_rx_byte;
    end

    assign w_byte      = r_mem[r_rd_ptr];
    assign w_is_prefix = is_prefix(w_byte);
    assign w_ext_ctx   = (r_state == DEC_EXT) || (r_state == DEC_EXT_BRK);
    assign w_make      = w_pop && !w_is_prefix && ((r_state == DEC_IDLE) || (r_state == DEC_EXT));
    assign w_brk       = w_pop && !w_is_prefix && ((r_state == DEC_BRK) || (r_state == DEC_EXT_BRK));
    assign w_is_lshift = !w_ext_ctx && (w_byte == SC_LSHIFT);
    assign w_is_rshift = !w_ext_ctx && (w_byte == SC_RSHIFT);
    assign w_is_caps   = !w_ext_ctx && (w_byte == SC_CAPS);
    // E0 12 is the fake shift some keyboards wrap around extended keys.
    assign w_is_fake   = w_ext_ctx && (w_byte == SC_LSHIFT);
    assign w_event     = w_make && !(w_is_lshift || w_is_rshift || w_is_caps || w_is_fake);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state     <= DEC_IDLE;
            r_lshift    <= 1'b0;
            r_rshift    <= 1'b0;
            r_caps      <= 1'b0;
            r_caps_held <= 1'b0;
            r_key_valid <= 1'b0;
            r_key_code  <= 8'h00;
            r_key_ext   <= 1'b0;
            r_key_state <= 2'b00;
        end else begin
            if (r_key_valid && key_ready) r_key_valid <= 1'b0;

            if (w_pop) begin
                case (r_state)
                    DEC_IDLE: begin
                        if (w_byte == SC_EXT)      r_state <= DEC_EXT;
                        else if (w_byte == SC_BRK) r_state <= DEC_BRK;
                    end
                    DEC_EXT: begin
                        if (w_byte == SC_BRK)      r_state <= DEC_EXT_BRK;
                        else if (w_byte != SC_EXT) r_state <= DEC_IDLE;
                    end
                    default: begin
                        if (!w_is_prefix) r_state <= DEC_IDLE;
                    end
                endcase
            end

            if (w_make && w_is_lshift) r_lshift <= 1'b1;
            if (w_brk && w_is_lshift)  r_lshift <= 1'b0;
            if (w_make && w_is_rshift) r_rshift <= 1'b1;
            if (w_brk && w_is_rshift)  r_rshift <= 1'b0;

            // Held CapsLock repeats must not keep toggling the lock.
            if (w_make && w_is_caps) begin
                if (!r_caps_held) r_caps <= ~r_caps;
                r_caps_held <= 1'b1;
            end
            if (w_brk && w_is_caps) r_caps_held <= 1'b0;

            if (w_event) begin
                r_key_code            <= w_byte;
                r_key_ext             <= w_ext_ctx;
                r_key_state[KS_CAPS]  <= r_caps;
                r_key_state[KS_SHIFT] <= r_lshift | r_rshift;
                r_key_valid           <= 1'b1;
            end
        end
    end

    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;
    assign key_ext   = r_key_ext;
    assign key_state = r_key_state;
    assign caps_led  = r_caps;
    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;

endmodule
